traffic_light_ctrl: RTL
=======================

# traffic_light_ctrl

Parametrised multi-approach traffic-light controller clocked by the slow `timer_clk` tick. It sequences N approaches in round-robin order: red → red+yellow → green → yellow → all-red → next approach. Each phase has a programmable duration, and the controller adds a pedestrian all-red walk phase and a yellow-flash maintenance mode. It sits directly behind the tick generator and drives lamp outputs for every approach.

## Interface
- `NUM_DIR`, 2 — number of approaches; must be ≥2.
- `REDYEL_TICKS`, 2 — red+yellow phase length in ticks.
- `GREEN_TICKS`, 8 — green phase length.
- `YELLOW_TICKS`, 2 — yellow phase length.
- `ALLRED_TICKS`, 1 — all-red clearance length.
- `PED_TICKS`, 6 — pedestrian walk length.
- `FLASH_TICKS`, 4 — half-period of the maintenance flash.
- All `*_TICKS` values must be ≥1. Counter width `CNT_W = $clog2(max of all *_TICKS)`, minimum 1.
- `timer_clk` in 1 — tick clock; all state changes on its rising edge.
- `rstb` in 1 — reset, asynchronous, active-low.
- `enable` in 1 — 0 freezes the FSM state and counter; outputs hold.
- `flash_mode` in 1 — level request for maintenance flash.
- `ped_req` in 1 — pedestrian request (pulse or level), sampled every edge.
- `ped_ack` out 1 — one-cycle pulse when the request is served.
- `ped_walk` out 1 — high during the walk phase.
- `red` out NUM_DIR — red lamp per approach.
- `yellow` out NUM_DIR — yellow lamp per approach.
- `green` out NUM_DIR — green lamp per approach.
- `active_dir` out $clog2(NUM_DIR) — approach currently owning the right of way.

## Operation
- States:
  - ALLRED: all red.
  - REDYEL: active approach red+yellow, others red.
  - GREEN: active approach green, others red.
  - YELLOW: active approach yellow, others red.
  - PED: all red, `ped_walk`=1.
  - FLASH: red/green all 0, `yellow` all toggling.
- Phase timing: on entry, the down-counter loads `DUR-1`. Each enabled edge it decrements. The edge on which count==0 performs the transition.
- Normal transitions:
  - ALLRED→REDYEL, with `active_dir` incrementing and wrapping `NUM_DIR-1`→0.
  - REDYEL→GREEN→YELLOW→ALLRED.
- Pedestrian latch: `ped_pend` is set by `ped_req`.
  - At YELLOW expiry with `ped_pend`=1: go to PED instead of ALLRED.
  - PED expiry → ALLRED (full clearance), then normal advance.
  - On the edge entering PED: `ped_pend` clears and `ped_ack` pulses for that cycle. `ped_req` on that same edge is dropped.
  - `ped_req` during PED is ignored.
- Flash entry is safe-sequenced:
  - `flash_mode`=1 in GREEN or REDYEL forces YELLOW on the next edge (counter reloads YELLOW).
  - YELLOW runs to expiry, then goes to ALLRED.
  - ALLRED or PED expiry with `flash_mode`=1 goes to FLASH.
  - Flash has priority over pedestrian.
- FLASH: `yellow` toggles every FLASH_TICKS ticks, starting at 1 on entry. `ped_pend` is held clear and `ped_req` is ignored. When `flash_mode`=0, the next edge goes to ALLRED with reload; `active_dir` is unchanged, so the next green is `active_dir+1`.
- `enable`=0 overrides everything: no transitions, counter held, `ped_req` still latched.

## Timing
- Outputs are a pure Moore decode of the registered state, `active_dir` and flash phase. There is no combinational path from inputs to outputs.
- Reset values:
  - Internal: state ALLRED, counter ALLRED_TICKS-1, `ped_pend`=0.
  - Outputs: `red`=all 1, `yellow`=0, `green`=0, `ped_walk`=0, `ped_ack`=0, `active_dir`=NUM_DIR-1, so the first green goes to approach 0.
- With `enable` held high, a phase of length D lasts exactly D edges.
- Per-approach period = REDYEL+GREEN+YELLOW+ALLRED (+PED when served).
- Reset asserted mid-phase returns to the reset values immediately and asynchronously.

## Structure
- Package `traffic_light_pkg` holds:
  - the state enum `tl_state_e`;
  - default tick constants;
  - the `tl_max` helper function used for CNT_W.
- Sub-module `tl_phase_counter`: loadable down-counter with hold (`load`, `load_val`, `hold`, `zero`). It is reused for the flash half-period.

## Test plan
- **Default sequence:** release reset with `enable`=1. Required response:
  - edge 1: approach 0 REDYEL;
  - edge 3: GREEN;
  - edge 11: YELLOW;
  - edge 13: ALLRED;
  - edge 14: approach 1 REDYEL;
  - edge 16: approach 1 GREEN;
  - edge 27: approach 0 REDYEL again.
- **Pedestrian:** pulse `ped_req` at edge 5. Required response:
  - edge 13: PED, with `ped_ack` high for one cycle and `ped_walk`=1 for 6 edges;
  - edge 19: ALLRED;
  - edge 20: approach 1 REDYEL.
- **Flash from green:** assert `flash_mode` at edge 6. Required response:
  - edge 7: YELLOW;
  - edge 9: ALLRED;
  - edge 10: FLASH, with `yellow` toggling every 4 edges;
  - drop `flash_mode` → ALLRED on the next edge, then approach 1 REDYEL.
- **Enable freeze:** deassert `enable` for 5 edges mid-GREEN. Required response: lamps unchanged, and the GREEN exit is delayed by exactly 5 edges.
- **Reset mid-operation:** assert `rstb` low during YELLOW. Required response: immediate all-red, `active_dir`=NUM_DIR-1; the sequence restarts per the default-sequence scenario.
- **Conflicts:** `ped_req` together with `flash_mode` → FLASH with no `ped_ack`. Repeat the default sequence with NUM_DIR=3 and confirm the wrap 2→0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types, default phase lengths and sizing helpers for the
// traffic-light controller.
package traffic_light_pkg;

  // Explicit encoding keeps the state values stable against older dumps.
  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_REDYEL = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_PED    = 3'd4,
    ST_FLASH  = 3'd5
  } tl_state_e;

  localparam int unsigned DEF_NUM_DIR      = 2;
  localparam int unsigned DEF_REDYEL_TICKS = 2;
  localparam int unsigned DEF_GREEN_TICKS  = 8;
  localparam int unsigned DEF_YELLOW_TICKS = 2;
  localparam int unsigned DEF_ALLRED_TICKS = 1;
  localparam int unsigned DEF_PED_TICKS    = 6;
  localparam int unsigned DEF_FLASH_TICKS  = 4;

  function automatic int unsigned tl_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that must hold values up to max_ticks-1.
  function automatic int unsigned tl_cnt_w(input int unsigned max_ticks);
    return (max_ticks > 1) ? $clog2(max_ticks) : 1;
  endfunction

endpackage

// File: rtl/tl_phase_counter.sv
// Loadable down-counter with hold. Stops at zero until reloaded; zero is a
// registered-state decode so it never depends on the current inputs.
module tl_phase_counter
  import traffic_light_pkg::*;
#(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         timer_clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down unless held or already at zero.
  always_ff @(posedge timer_clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic-light controller. Round-robin sequencing
// red -> red+yellow -> green -> yellow -> all-red per approach, with a
// pedestrian all-red walk phase and a safe-sequenced yellow-flash mode.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned NUM_DIR      = DEF_NUM_DIR,
  parameter int unsigned REDYEL_TICKS = DEF_REDYEL_TICKS,
  parameter int unsigned GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int unsigned ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int unsigned PED_TICKS    = DEF_PED_TICKS,
  parameter int unsigned FLASH_TICKS  = DEF_FLASH_TICKS
) (
  input  logic                       timer_clk,
  input  logic                       rstb,
  input  logic                       enable,
  input  logic                       flash_mode,
  input  logic                       ped_req,
  output logic                       ped_ack,
  output logic                       ped_walk,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int unsigned DIR_W = $clog2(NUM_DIR);
  localparam int unsigned MAX_TICKS =
    tl_max(tl_max(tl_max(REDYEL_TICKS, GREEN_TICKS), tl_max(YELLOW_TICKS, ALLRED_TICKS)),
           tl_max(PED_TICKS, FLASH_TICKS));
  localparam int unsigned CNT_W = tl_cnt_w(MAX_TICKS);

  localparam logic [CNT_W-1:0] LD_REDYEL = CNT_W'(REDYEL_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(PED_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_TICKS - 1);
  localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIR - 1);

  tl_state_e        state, next_state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_hold;
  logic             cnt_zero;
  logic             dir_adv;
  logic             enter_ped;
  logic             enter_flash;
  logic             ped_pend;
  logic             flash_yel;
  logic             flash_step;
  logic             f_load;
  logic             f_hold;
  logic             f_zero;
  logic [NUM_DIR-1:0] dir_mask;

  // Phase-duration counter; frozen while disabled and unused during flash.
  assign cnt_hold = !enable || (state == ST_FLASH);

  tl_phase_counter #(
    .W       (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_phase_cnt (
    .timer_clk (timer_clk),
    .rstb      (rstb),
    .load      (cnt_load),
    .load_val  (cnt_val),
    .hold      (cnt_hold),
    .zero      (cnt_zero)
  );

  // Flash half-period counter, reloaded on entry and on every toggle.
  assign flash_step = enable && (state == ST_FLASH) && f_zero;
  assign f_load     = enter_flash || flash_step;
  assign f_hold     = !enable || (state != ST_FLASH);

  tl_phase_counter #(
    .W       (CNT_W),
    .RST_VAL (LD_FLASH)
  ) u_flash_cnt (
    .timer_clk (timer_clk),
    .rstb      (rstb),
    .load      (f_load),
    .load_val  (LD_FLASH),
    .hold      (f_hold),
    .zero      (f_zero)
  );

  // Next-state selection; every transition reloads the phase counter except
  // entry to FLASH, which is timed by the flash counter instead.
  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    dir_adv     = 1'b0;
    enter_ped   = 1'b0;
    enter_flash = 1'b0;
    if (enable) begin
      case (state)
        ST_ALLRED: begin
          if (cnt_zero) begin
            if (flash_mode) begin
              next_state  = ST_FLASH;
              enter_flash = 1'b1;
            end else begin
              next_state = ST_REDYEL;
              cnt_load   = 1'b1;
              cnt_val    = LD_REDYEL;
              dir_adv    = 1'b1;
            end
          end
        end
        ST_REDYEL: begin
          if (flash_mode) begin
            next_state = ST_YELLOW;
            cnt_load   = 1'b1;
            cnt_val    = LD_YELLOW;
          end else if (cnt_zero) begin
            next_state = ST_GREEN;
            cnt_load   = 1'b1;
            cnt_val    = LD_GREEN;
          end
        end
        ST_GREEN: begin
          if (flash_mode || cnt_zero) begin
            next_state = ST_YELLOW;
            cnt_load   = 1'b1;
            cnt_val    = LD_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (cnt_zero) begin
            // A pending flash request beats a pending pedestrian.
            if (!flash_mode && ped_pend) begin
              next_state = ST_PED;
              cnt_load   = 1'b1;
              cnt_val    = LD_PED;
              enter_ped  = 1'b1;
            end else begin
              next_state = ST_ALLRED;
              cnt_load   = 1'b1;
              cnt_val    = LD_ALLRED;
            end
          end
        end
        ST_PED: begin
          if (cnt_zero) begin
            if (flash_mode) begin
              next_state  = ST_FLASH;
              enter_flash = 1'b1;
            end else begin
              next_state = ST_ALLRED;
              cnt_load   = 1'b1;
              cnt_val    = LD_ALLRED;
            end
          end
        end
        ST_FLASH: begin
          if (!flash_mode) begin
            next_state = ST_ALLRED;
            cnt_load   = 1'b1;
            cnt_val    = LD_ALLRED;
          end
        end
        default: begin
          next_state = ST_ALLRED;
          cnt_load   = 1'b1;
          cnt_val    = LD_ALLRED;
        end
      endcase
    end
  end

  // State register and right-of-way owner; reset owner is the last approach
  // so the first advance hands green to approach 0.
  always_ff @(posedge timer_clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_ALLRED;
      active_dir <= DIR_LAST;
    end else begin
      state <= next_state;
      if (dir_adv) begin
        active_dir <= (active_dir == DIR_LAST) ? '0 : active_dir + 1'b1;
      end
    end
  end

  // Pedestrian latch: served requests and requests during walk/flash are dropped.
  always_ff @(posedge timer_clk or negedge rstb) begin
    if (!rstb) begin
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      ped_ack <= enter_ped;
      if (enter_ped || (state == ST_PED) || (state == ST_FLASH)) begin
        ped_pend <= 1'b0;
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end
    end
  end

  // Flash lamp phase: lit on entry, inverted every half-period.
  always_ff @(posedge timer_clk or negedge rstb) begin
    if (!rstb) begin
      flash_yel <= 1'b0;
    end else if (enter_flash) begin
      flash_yel <= 1'b1;
    end else if (flash_step) begin
      flash_yel <= ~flash_yel;
    end
  end

  // One-hot select of the approach owning the right of way.
  always_comb begin
    dir_mask = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      dir_mask[i] = (active_dir == DIR_W'(i));
    end
  end

  // Moore lamp decode from registered state only.
  always_comb begin
    red      = '1;
    yellow   = '0;
    green    = '0;
    ped_walk = 1'b0;
    case (state)
      ST_REDYEL: begin
        yellow = dir_mask;
      end
      ST_GREEN: begin
        red   = ~dir_mask;
        green = dir_mask;
      end
      ST_YELLOW: begin
        red    = ~dir_mask;
        yellow = dir_mask;
      end
      ST_PED: begin
        ped_walk = 1'b1;
      end
      ST_FLASH: begin
        red    = '0;
        yellow = {NUM_DIR{flash_yel}};
      end
      default: begin
        red = '1;
      end
    endcase
  end

endmodule
